// File: rtl/iter_alu.sv
// iter_alu: multi-cycle ALU with a valid/ready request and a valid/ready result.
// Single-cycle operations complete one cycle after accept. Shifts move the
// working register one bit per cycle, so a shift by N delivers its result
// N+1 cycles after accept.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   request handshake (o_ready high only in IDLE)
//   i_op, i_a, i_b      operation (mypkg::alu_op_e), operands; i_b low bits = shift amount
//   o_valid / i_ready   result handshake; o_result is zero while o_valid is low

package mypkg;
  typedef enum logic [3:0] {
    A_ADD  = 4'd0,
    A_SUB  = 4'd1,
    A_SLT  = 4'd2,
    A_SLTU = 4'd3,
    A_XOR  = 4'd4,
    A_OR   = 4'd5,
    A_AND  = 4'd6,
    A_SLL  = 4'd7,
    A_SRL  = 4'd8,
    A_SRA  = 4'd9,
    A_LUI  = 4'd10
  } alu_op_e;
endpackage

module iter_alu
  import mypkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [SH_W-1:0] CNT_ZERO = {SH_W{1'b0}};
  localparam logic [SH_W-1:0] CNT_ONE  = {{(SH_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_op;
  logic [3:0]        w_op_nxt;
  logic [DATA_W-1:0] r_work;
  logic [DATA_W-1:0] w_work_nxt;
  logic [SH_W-1:0]   r_cnt;
  logic [SH_W-1:0]   w_cnt_nxt;
  logic              r_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic              w_accept;
  logic [SH_W-1:0]   w_shamt;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == A_SLL) || (op == A_SRL) || (op == A_SRA);
  endfunction

  // Single-cycle operations; shift ops and unused codes 11-15 yield zero here.
  function automatic logic [DATA_W-1:0] alu_eval(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    res = {DATA_W{1'b0}};
    case (op)
      A_ADD:   res = a + b;
      A_SUB:   res = a - b;
      A_SLT:   res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      A_SLTU:  res = {{(DATA_W-1){1'b0}}, (a < b)};
      A_XOR:   res = a ^ b;
      A_OR:    res = a | b;
      A_AND:   res = a & b;
      A_LUI:   res = b;
      default: res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  // One-bit step of the iterative shifter. SRA copies the current MSB, which
  // is always the latched a[DATA_W-1] because every step preserves it.
  function automatic logic [DATA_W-1:0] shift_one(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] res;
    res = v;
    case (op)
      A_SLL:   res = {v[DATA_W-2:0], 1'b0};
      A_SRL:   res = {1'b0, v[DATA_W-1:1]};
      A_SRA:   res = {v[DATA_W-1], v[DATA_W-1:1]};
      default: res = v;
    endcase
    return res;
  endfunction

  assign w_shamt  = i_b[SH_W-1:0];
  // r_ready already implies IDLE; the state term keeps accept robust.
  assign w_accept = i_valid && r_ready && (r_state == S_IDLE);

  // Next-state, working register and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt = i_op;
          if (is_shift(i_op)) begin
            w_work_nxt  = i_a;
            w_cnt_nxt   = w_shamt;
            w_state_nxt = (w_shamt == CNT_ZERO) ? S_DONE : S_SHIFT;
          end else begin
            w_work_nxt  = alu_eval(i_op, i_a, i_b);
            w_cnt_nxt   = CNT_ZERO;
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        w_work_nxt = shift_one(r_op, r_work);
        w_cnt_nxt  = r_cnt - CNT_ONE;
        // Counter reaches zero on this edge: the last shift step lands in DONE.
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_work_nxt  = {DATA_W{1'b0}};
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= 4'd0;
      r_work   <= {DATA_W{1'b0}};
      r_cnt    <= CNT_ZERO;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= {DATA_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      // Ready follows the state we are entering, so it rises one cycle after
      // DONE completes and never in the completing cycle itself.
      r_ready  <= (w_state_nxt == S_IDLE);
      r_valid  <= (w_state_nxt == S_DONE);
      r_result <= (w_state_nxt == S_DONE) ? w_work_nxt : {DATA_W{1'b0}};
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_iter_alu.sv
module tb_iter_alu;
  import mypkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;

  int n_cmp;
  int n_err;

  iter_alu #(.DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: results straight from the operation definitions.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    n = b[4:0];
    case (op)
      A_ADD:   return a + b;
      A_SUB:   return a - b;
      A_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      A_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      A_XOR:   return a ^ b;
      A_OR:    return a | b;
      A_AND:   return a & b;
      A_SLL:   return a << n;
      A_SRL:   return a >> n;
      A_SRA:   return $unsigned($signed(a) >>> n);
      A_LUI:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
    if ((op == A_SLL || op == A_SRL || op == A_SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Issue one request (caller is just after an edge with o_ready high) and
  // wait, bounded, for o_valid. lat counts edges from accept to o_valid.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic rdy_done);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = 4'($urandom); i_a = $urandom; i_b = $urandom;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      i_a = $urandom; i_b = $urandom;
    end
    res = o_result;
    rdy_done = o_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_op = 4'd0; i_a = 32'd0; i_b = 32'd0;
    #2;
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", o_result); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_early got %b want 0", o_ready); end
    @(posedge clk); #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL release_valid got %b want 0", o_valid); end
  endtask

  task automatic test_directed();
    logic [3:0]  d_op  [7];
    logic [31:0] d_a   [7];
    logic [31:0] d_b   [7];
    int          d_lat [7];
    logic [31:0] d_res [7];
    int lat; logic [31:0] res; logic rdy;
    d_op  = '{A_ADD, A_SLT, A_SLTU, A_SRA, A_SRL, A_SLL, 4'hF};
    d_a   = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h1, 32'h12345678};
    d_b   = '{32'h1, 32'h1, 32'h1, 32'd31, 32'd31, 32'd0, 32'h9ABCDEF0};
    d_lat = '{1, 1, 1, 32, 32, 1, 1};
    d_res = '{32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0};
    i_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      do_op(d_op[k], d_a[k], d_b[k], lat, res, rdy);
      n_cmp++; if (lat != d_lat[k]) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", k, lat, d_lat[k]); end
      n_cmp++; if (res !== d_res[k]) begin n_err++; $display("FAIL dir%0d_result got %h want %h", k, res, d_res[k]); end
      n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL dir%0d_ready_in_done got %b want 0", k, rdy); end
      @(posedge clk); #1;
      n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'd0) begin
        n_err++; $display("FAIL dir%0d_after got rdy=%b vld=%b res=%h want 1 0 0", k, o_ready, o_valid, o_result);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res; logic rdy;
    logic [3:0] op; logic [31:0] a, b;
    i_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
      do_op(op, a, b, lat, res, rdy);
      n_cmp++; if (lat != ref_lat(op, b)) begin n_err++; $display("FAIL rnd%0d_latency op=%0d got %0d want %0d", k, op, lat, ref_lat(op, b)); end
      n_cmp++; if (res !== ref_res(op, a, b)) begin n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h want %h", k, op, a, b, res, ref_res(op, a, b)); end
      @(posedge clk); #1;
      n_cmp++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_return got rdy=%b vld=%b want 1 0", k, o_ready, o_valid); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] res, a, exp_r; logic rdy; int vcount;
    a = $urandom | 32'h80000000;
    exp_r = ref_res(A_SRA, a, 32'd5);
    i_ready = 1'b0;
    do_op(A_SRA, a, 32'd5, lat, res, rdy);
    n_cmp++; if (lat != 6) begin n_err++; $display("FAIL bp_latency got %0d want 6", lat); end
    n_cmp++; if (res !== exp_r) begin n_err++; $display("FAIL bp_result got %h want %h", res, exp_r); end
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_op = A_ADD; i_a = $urandom; i_b = $urandom;
      @(posedge clk); #1;
      n_cmp++; if (o_valid !== 1'b1 || o_result !== exp_r || o_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d got vld=%b res=%h rdy=%b want 1 %h 0", k, o_valid, o_result, o_ready, exp_r);
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'd0) begin
      n_err++; $display("FAIL bp_release got vld=%b rdy=%b res=%h want 0 1 0", o_valid, o_ready, o_result);
    end
    vcount = 0;
    repeat (6) begin @(posedge clk); #1; if (o_valid === 1'b1) vcount++; end
    n_cmp++; if (vcount != 0) begin n_err++; $display("FAIL bp_not_queued got %0d results want 0", vcount); end
  endtask

  task automatic test_reset_mid_shift();
    int vcount;
    i_ready = 1'b1;
    i_valid = 1'b1; i_op = A_SLL; i_a = $urandom | 32'h1; i_b = 32'd20;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0 || o_result !== 32'd0 || o_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_abort got vld=%b res=%h rdy=%b want 0 0 0", o_valid, o_result, o_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", o_ready); end
    vcount = 0;
    repeat (30) begin @(posedge clk); #1; if (o_valid !== 1'b0 || o_result !== 32'd0) vcount++; end
    n_cmp++; if (vcount != 0) begin n_err++; $display("FAIL midrst_stale got %0d cycles with output want 0", vcount); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8];
    logic [31:0] q[$];
    logic [31:0] exp_r;
    int vcount;
    ops = '{A_ADD, A_SUB, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_LUI};
    i_ready = 1'b1;
    vcount = 0;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_op = ops[$urandom_range(0, 7)]; i_a = $urandom; i_b = $urandom;
      if (o_ready === 1'b1) q.push_back(ref_res(i_op, i_a, i_b));
      @(posedge clk); #1;
      if (o_valid === 1'b1) begin
        vcount++;
        exp_r = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
        n_cmp++; if (o_result !== exp_r) begin n_err++; $display("FAIL b2b_result%0d got %h want %h", k, o_result, exp_r); end
      end
    end
    i_valid = 1'b0;
    n_cmp++; if (vcount != 5) begin n_err++; $display("FAIL b2b_count got %0d want 5", vcount); end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; SHALL be a power of two, at least 8.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_valid  input  1  request valid from issuing stage.
REQ-005 o_ready  output  1  block can accept a request this cycle.
REQ-006 i_op  input  4  operation, alu_op_e encoding from mypkg (A_ADD=0 .. A_LUI=10).
REQ-007 i_a  input  DATA_W  operand A.
REQ-008 i_b  input  DATA_W  operand B; low log2(DATA_W) bits are the shift amount for shift ops.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_result  output  DATA_W  result.

Function
REQ-012 States SHALL be IDLE, SHIFT and DONE; the reset state SHALL be IDLE.
REQ-013 o_ready SHALL be 1 only in IDLE; a request is accepted when i_valid && o_ready at a rising edge.
REQ-014 On accept, i_op, i_a and the shift amount SHALL be latched; inputs are don't-care afterwards.
REQ-015 Non-shift ops SHALL go IDLE->DONE, with o_valid high on the cycle after accept (latency 1).
REQ-016 A_ADD: a+b; A_SUB: a-b; both modulo 2^DATA_W, carry discarded.
REQ-017 A_SLT: 1 if a<b signed, else 0; A_SLTU: same, unsigned; the upper bits SHALL be zero.
REQ-018 A_XOR, A_OR, A_AND: bitwise; A_LUI: result = b.
REQ-019 Op codes 11-15 SHALL produce result 0 with latency 1 and no error indication.
REQ-020 Shift ops (A_SLL, A_SRL, A_SRA) with shift amount N>0 SHALL go IDLE->SHIFT and shift the working register by exactly one bit per cycle.
REQ-021 In SHIFT, a down-counter loaded with N SHALL decrement once per cycle; the state SHALL move to DONE when the counter reaches 0, giving o_valid N+1 cycles after accept.
REQ-022 A shift with N=0 SHALL go directly to DONE (latency 1) with result = a.
REQ-023 A_SLL SHALL fill with 0, A_SRL SHALL fill with 0, and A_SRA SHALL replicate the latched a[DATA_W-1].
REQ-024 In DONE, o_valid SHALL be 1 and o_result SHALL hold stable until i_ready=1; then the state SHALL return to IDLE on that edge.
REQ-025 A request SHALL NOT be accepted in the cycle DONE completes; o_ready rises the next cycle, giving a minimum issue interval of 2 cycles.
REQ-026 o_result SHALL be 0 whenever o_valid=0.
REQ-027 i_valid asserted outside IDLE SHALL be ignored, and the request SHALL NOT be queued.

Reset
REQ-028 While i_rst_n=0: state SHALL be IDLE, o_valid=0, o_ready=0, o_result=0, and counter and working register SHALL be 0.
REQ-029 o_ready SHALL go to 1 on the first rising edge after i_rst_n deasserts.
REQ-030 Reset asserted during SHIFT or DONE SHALL abort the operation immediately; no result SHALL be delivered after release.

Verification
REQ-031 A_ADD, a=0xFFFFFFFF, b=1, i_ready=1 -> o_valid 1 cycle later, o_result=0x00000000, then o_ready=1 on the next cycle.
REQ-032 A_SLT, a=0x80000000, b=1 -> result 1; A_SLTU with the same operands -> result 0.
REQ-033 A_SRA, a=0x80000000, b=31 -> o_valid exactly 32 cycles after accept, o_result=0xFFFFFFFF; A_SRL with the same operands -> 0x00000001.
REQ-034 A_SLL, a=0x1, b=0 -> latency 1, result 0x1; op=4'hF -> latency 1, result 0.
REQ-035 Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid and o_result stable; i_valid pulsed meanwhile -> not accepted.
REQ-036 i_rst_n pulsed low mid-SHIFT (A_SLL, b=20, after 5 cycles) -> o_valid=0 and o_result=0 at once; after release, o_ready=1 and no stale result appears.
